add_arbiter: RTL

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter_pkg.sv | 13 +
 rtl/Full_Adder_8bit.sv | 26 ++
 rtl/add_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/add_arbiter_pkg.sv
// Shared definitions for the add_arbiter slice: FSM state encodings and size limits.
package add_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int PKG_DATA_W = 8;
  localparam int MAX_NREQ   = 4;

endpackage

// File: rtl/Full_Adder_8bit.sv
// 8-bit ripple-carry adder shared by all requesters of add_arbiter.
module Full_Adder_8bit
  import add_arbiter_pkg::*;
(
  input  logic [PKG_DATA_W-1:0] a,
  input  logic [PKG_DATA_W-1:0] b,
  input  logic                  cin,
  output logic [PKG_DATA_W-1:0] sum,
  output logic                  cout
);

  logic [PKG_DATA_W:0] carry;

  assign carry[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < PKG_DATA_W; gi++) begin : g_bit
      assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = carry[PKG_DATA_W];

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one Full_Adder_8bit among NREQ requesters (IDLE->CALC->RESP).
// Define ADD_ARBITER_CHAIN_EN to keep a per-requester carry flag selectable through req_chain.
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DATA_W-1:0]   req_a,
  input  logic [NREQ*DATA_W-1:0]   req_b,
  input  logic [NREQ-1:0]          req_cin,
  input  logic [NREQ-1:0]          req_chain,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [1:0]               rsp_id,
  output logic [DATA_W-1:0]        rsp_sum,
  output logic                     rsp_cout
);

  // Requester inputs padded to MAX_NREQ so a 2-bit index is always in range.
  logic [MAX_NREQ-1:0] valid_pad;
  logic [MAX_NREQ-1:0] cin_pad;
  logic [DATA_W-1:0]   a_arr [MAX_NREQ];
  logic [DATA_W-1:0]   b_arr [MAX_NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < MAX_NREQ; gi++) begin : g_pad
      if (gi < NREQ) begin : g_used
        assign valid_pad[gi] = req_valid[gi];
        assign cin_pad[gi]   = req_cin[gi];
        assign a_arr[gi]     = req_a[gi*DATA_W +: DATA_W];
        assign b_arr[gi]     = req_b[gi*DATA_W +: DATA_W];
      end else begin : g_absent
        assign valid_pad[gi] = 1'b0;
        assign cin_pad[gi]   = 1'b0;
        assign a_arr[gi]     = '0;
        assign b_arr[gi]     = '0;
      end
    end
  endgenerate

  state_e              state_q, state_d;
  logic [1:0]          rr_q, rr_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                cin_q, cin_d;
  logic [1:0]          id_q, id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_sum_q, rsp_sum_d;
  logic                rsp_cout_q, rsp_cout_d;
  logic [1:0]          rsp_id_q, rsp_id_d;

  logic [DATA_W-1:0]   add_sum;
  logic                add_cout;

  logic                win_found;
  logic [1:0]          win_idx;
  logic [2:0]          scan_idx;
  logic [2:0]          next_ptr;
  logic                cin_eff;
  logic [MAX_NREQ-1:0] grant;

`ifdef ADD_ARBITER_CHAIN_EN
  logic [MAX_NREQ-1:0] chain_pad;
  logic [MAX_NREQ-1:0] carry_q, carry_d;

  assign chain_pad = MAX_NREQ'(req_chain);
`else
  logic unused_chain;

  assign unused_chain = ^req_chain;
`endif

  Full_Adder_8bit u_adder (
    .a    (a_q),
    .b    (b_q),
    .cin  (cin_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Round-robin scan starting at rr_q; first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_q} + 3'(k);
      if (scan_idx >= 3'(NREQ)) begin
        scan_idx = scan_idx - 3'(NREQ);
      end
      if (!win_found && valid_pad[scan_idx[1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[1:0];
      end
    end

    next_ptr = {1'b0, win_idx} + 3'd1;
    if (next_ptr >= 3'(NREQ)) begin
      next_ptr = '0;
    end

`ifdef ADD_ARBITER_CHAIN_EN
    cin_eff = chain_pad[win_idx] ? carry_q[win_idx] : cin_pad[win_idx];
`else
    cin_eff = cin_pad[win_idx];
`endif
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_id_d    = rsp_id_q;
    grant       = '0;
`ifdef ADD_ARBITER_CHAIN_EN
    carry_d     = carry_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant[win_idx] = 1'b1;
          state_d        = ST_CALC;
          a_d            = a_arr[win_idx];
          b_d            = b_arr[win_idx];
          cin_d          = cin_eff;
          id_d           = win_idx;
          rr_d           = next_ptr[1:0];
        end
      end
      ST_CALC: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_sum_d   = add_sum;
        rsp_cout_d  = add_cout;
        rsp_id_d    = id_q;
`ifdef ADD_ARBITER_CHAIN_EN
        carry_d[id_q] = add_cout;
`endif
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
`ifdef ADD_ARBITER_CHAIN_EN
      carry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= rsp_id_d;
`ifdef ADD_ARBITER_CHAIN_EN
      carry_q     <= carry_d;
`endif
    end
  end

  // Grants are combinational so a requester that drops valid before the edge is never charged.
  assign req_ready = rst_n ? grant[NREQ-1:0] : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;

endmodule
